wrr_credit_arbiter: RTL and testbench

Weighted round-robin arbiter with per-requestor programmable weights, per-requestor credit counters and a registered grant/ack handshake. It is the parametrised successor to the fixed-weight RR wrapper. The arbiter is self-contained, with no RR submodule. Weights are runtime-loadable, weight 0 disables a requestor, and a granted requestor keeps the pointer until its credits run out. It sits in front of shared buses or ports where each master holds a grant until the target acknowledges.

---
 rtl/wrr_credit_arbiter.sv | 142 ++++++++++++++
 tb/tb_wrr_credit_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/wrr_credit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wrr_credit_arbiter
// Purpose  : Weighted round-robin arbiter with runtime weights, per-requestor
//            credit counters and a registered grant held until ack.
// Revision : 1.0 - initial release
// ============================================================================
module wrr_credit_arbiter #(
    parameter int NUM_REQ        = 8,
    parameter int WEIGHT_W       = 4,
    parameter int DEFAULT_WEIGHT = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic                          ack,
    input  logic                          cfg_load,
    input  logic [NUM_REQ*WEIGHT_W-1:0]   cfg_weight,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [$clog2(NUM_REQ)-1:0]    gnt_id,
    output logic                          gnt_valid,
    output logic                          replenish
);

    localparam int c_ID_W = $clog2(NUM_REQ);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [WEIGHT_W-1:0]   r_weight [NUM_REQ];
    logic [WEIGHT_W-1:0]   r_credit [NUM_REQ];
    logic [c_ID_W-1:0]     r_ptr, w_ptr_nxt;
    logic [NUM_REQ-1:0]    r_gnt, w_gnt_nxt;
    logic [c_ID_W-1:0]     r_gnt_id, w_gnt_id_nxt;
    logic [NUM_REQ-1:0]    w_eligible, w_live;
    logic                  w_found;
    logic [c_ID_W-1:0]     w_sel;
    logic [c_ID_W:0]       w_scan;
    logic [c_ID_W-1:0]     w_gnt_inc;
    logic                  w_reload, w_consume, w_replenish;

    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
            assign w_live[i]     = req[i] & (r_weight[i] != '0);
            assign w_eligible[i] = w_live[i] & (r_credit[i] != '0);
        end
    endgenerate

    // Rotating scan: the extra bit in w_scan lets the sum wrap at any NUM_REQ
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_scan  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_scan = {1'b0, r_ptr} + (c_ID_W+1)'(k);
            if (w_scan >= (c_ID_W+1)'(NUM_REQ))
                w_scan = w_scan - (c_ID_W+1)'(NUM_REQ);
            if (!w_found && w_eligible[w_scan[c_ID_W-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_scan[c_ID_W-1:0];
            end
        end
    end

    assign w_gnt_inc = (r_gnt_id == c_ID_W'(NUM_REQ-1)) ? '0 : r_gnt_id + c_ID_W'(1);

    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = r_gnt;
        w_gnt_id_nxt = r_gnt_id;
        w_ptr_nxt    = r_ptr;
        w_reload     = 1'b0;
        w_consume    = 1'b0;
        w_replenish  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt  = GRANT;
                    w_gnt_nxt    = NUM_REQ'(1) << w_sel;
                    w_gnt_id_nxt = w_sel;
                end else if (|w_live && !cfg_load) begin
                    w_reload    = 1'b1;
                    w_replenish = 1'b1;
                end
            end
            GRANT: begin
                if (ack) begin
                    w_state_nxt  = IDLE;
                    w_gnt_nxt    = '0;
                    w_gnt_id_nxt = '0;
                    w_consume    = !cfg_load;
                    // The grantee keeps priority only while it still has credit left
                    w_ptr_nxt    = (r_credit[r_gnt_id] > WEIGHT_W'(1)) ? r_gnt_id : w_gnt_inc;
                end else if (!req[r_gnt_id]) begin
                    w_state_nxt  = IDLE;
                    w_gnt_nxt    = '0;
                    w_gnt_id_nxt = '0;
                    w_ptr_nxt    = w_gnt_inc;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_gnt    <= '0;
            r_gnt_id <= '0;
            r_ptr    <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                r_weight[i] <= WEIGHT_W'(DEFAULT_WEIGHT);
                r_credit[i] <= WEIGHT_W'(DEFAULT_WEIGHT);
            end
        end else begin
            r_state  <= w_state_nxt;
            r_gnt    <= w_gnt_nxt;
            r_gnt_id <= w_gnt_id_nxt;
            r_ptr    <= w_ptr_nxt;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (cfg_load) begin
                    r_weight[i] <= cfg_weight[i*WEIGHT_W +: WEIGHT_W];
                    r_credit[i] <= cfg_weight[i*WEIGHT_W +: WEIGHT_W];
                end else if (w_reload) begin
                    r_credit[i] <= r_weight[i];
                end else if (w_consume && (c_ID_W'(i) == r_gnt_id) && (r_credit[i] != '0)) begin
                    r_credit[i] <= r_credit[i] - WEIGHT_W'(1);
                end
            end
        end
    end

    assign gnt       = r_gnt;
    assign gnt_id    = r_gnt_id;
    assign gnt_valid = |r_gnt;
    assign replenish = w_replenish & ~rst;

endmodule
`default_nettype wire

// File: tb/tb_wrr_credit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wrr_credit_arbiter
// Purpose  : Directed scenarios plus randomized traffic against a cycle model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wrr_credit_arbiter;

    localparam int N = 5;
    localparam int W = 4;
    localparam int D = 3;

    logic                 clk = 1'b0;
    logic                 rst, ack, cfg_load;
    logic [N-1:0]         req;
    logic [N*W-1:0]       cfg_weight;
    logic [N-1:0]         gnt;
    logic [$clog2(N)-1:0] gnt_id;
    logic                 gnt_valid, replenish;

    wrr_credit_arbiter #(.NUM_REQ(N), .WEIGHT_W(W), .DEFAULT_WEIGHT(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .ack        (ack),
        .cfg_load   (cfg_load),
        .cfg_weight (cfg_weight),
        .gnt        (gnt),
        .gnt_id     (gnt_id),
        .gnt_valid  (gnt_valid),
        .replenish  (replenish)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int ev_log[$];

    // Reference: credits/weights as plain integers, one holder at a time
    int m_w [N];
    int m_c [N];
    int m_ptr, m_g;
    bit m_hold;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < N; i++) begin
            m_w[i] = D;
            m_c[i] = D;
        end
        m_ptr  = 0;
        m_g    = 0;
        m_hold = 1'b0;
    endfunction

    function automatic int m_pick(input logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (r[i] && m_w[i] != 0 && m_c[i] != 0) return i;
        end
        return -1;
    endfunction

    function automatic bit m_any_live(input logic [N-1:0] r);
        for (int i = 0; i < N; i++)
            if (r[i] && m_w[i] != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [N*W-1:0] pack_all(input int v);
        logic [N*W-1:0] p;
        for (int i = 0; i < N; i++) p[i*W +: W] = W'(v);
        return p;
    endfunction

    task automatic cycle(input logic [N-1:0] r, input logic a, input logic cl,
                         input logic [N*W-1:0] cw, input logic rs);
        int  pick, old;
        bit  exp_rep;
        req = r; ack = a; cfg_load = cl; cfg_weight = cw; rst = rs;
        #1;
        pick    = m_pick(r);
        exp_rep = !rs && !m_hold && pick < 0 && m_any_live(r) && !cl;
        check_eq("gnt",       32'(gnt),       m_hold ? (32'd1 << m_g) : 32'd0);
        check_eq("gnt_id",    32'(gnt_id),    m_hold ? 32'(m_g) : 32'd0);
        check_eq("gnt_valid", 32'(gnt_valid), 32'(m_hold));
        check_eq("replenish", 32'(replenish), 32'(exp_rep));
        if (gnt_valid) ev_log.push_back(int'(gnt_id));
        if (replenish) ev_log.push_back(9);
        if (rs) begin
            m_reset();
        end else begin
            if (m_hold) begin
                old = m_c[m_g];
                if (a) begin
                    m_ptr = (old > 1) ? m_g : (m_g + 1) % N;
                    if (!cl && old > 0) m_c[m_g] = old - 1;
                    m_hold = 1'b0;
                end else if (!r[m_g]) begin
                    m_ptr  = (m_g + 1) % N;
                    m_hold = 1'b0;
                end
            end else if (pick >= 0) begin
                m_hold = 1'b1;
                m_g    = pick;
            end else if (exp_rep) begin
                for (int i = 0; i < N; i++) m_c[i] = m_w[i];
            end
            if (cl)
                for (int i = 0; i < N; i++) m_w[i] = int'(cw[i*W +: W]);
            if (cl)
                for (int i = 0; i < N; i++) m_c[i] = m_w[i];
        end
        @(negedge clk);
    endtask

    task automatic check_log(input string tag, input int exp[$]);
        foreach (exp[i])
            check_eq($sformatf("%s[%0d]", tag, i),
                     32'((i < ev_log.size()) ? ev_log[i] : -1), 32'(exp[i]));
        ev_log.delete();
    endtask

    initial begin
        logic [N-1:0]   r;
        logic [N*W-1:0] cw;
        rst = 1'b1; req = '0; ack = 1'b0; cfg_load = 1'b0; cfg_weight = '0;
        repeat (2) @(negedge clk);
        m_reset();
        cycle('0, 1'b0, 1'b0, '0, 1'b1);
        ev_log.delete();

        // Two requestors sharing weight 3 each, immediate ack
        repeat (16) cycle(5'b00101, m_hold, 1'b0, '0, 1'b0);
        check_log("seq_basic", '{0, 0, 0, 2, 2, 2, 9, 0});

        // Weights r0=2, r1=0, r2=1: r1 must never be served
        cycle('0, 1'b0, 1'b0, '0, 1'b1);
        cw = '0; cw[3:0] = 4'd2; cw[11:8] = 4'd1;
        cycle('0, 1'b0, 1'b1, cw, 1'b0);
        ev_log.delete();
        repeat (16) cycle(5'b00111, m_hold, 1'b0, '0, 1'b0);
        check_log("seq_weighted", '{0, 0, 2, 9, 0, 0, 2});

        // Grantee drops req before ack: no credit spent, pointer moves on
        cycle('0, 1'b0, 1'b0, '0, 1'b1);
        ev_log.delete();
        cycle(5'b00011, 1'b0, 1'b0, '0, 1'b0);
        cycle(5'b00010, 1'b0, 1'b0, '0, 1'b0);
        repeat (2) cycle(5'b00010, m_hold, 1'b0, '0, 1'b0);
        repeat (8) cycle(5'b00001, m_hold, 1'b0, '0, 1'b0);
        check_log("seq_drop", '{0, 1, 0, 0, 0, 9});

        // cfg_load coinciding with ack: credit becomes 5, not 4
        cycle('0, 1'b0, 1'b0, '0, 1'b1);
        ev_log.delete();
        cycle(5'b00001, 1'b0, 1'b0, '0, 1'b0);
        cycle(5'b00001, 1'b1, 1'b1, pack_all(5), 1'b0);
        repeat (14) cycle(5'b00001, m_hold, 1'b0, '0, 1'b0);
        check_log("seq_load_ack", '{0, 0, 0, 0, 0, 0, 9});

        // Pointer wrap 4 -> 0 with weights of 1
        cycle('0, 1'b0, 1'b0, '0, 1'b1);
        cycle('0, 1'b0, 1'b1, pack_all(1), 1'b0);
        ev_log.delete();
        cycle(5'b01000, 1'b0, 1'b0, '0, 1'b0);
        cycle(5'b01000, m_hold, 1'b0, '0, 1'b0);
        repeat (10) cycle(5'b10001, m_hold, 1'b0, '0, 1'b0);
        check_log("seq_wrap", '{3, 4, 0, 9, 4});

        // Reset during a grant restores default weights; late ack ignored
        cycle('0, 1'b0, 1'b1, pack_all(1), 1'b0);
        ev_log.delete();
        cycle(5'b00001, 1'b0, 1'b0, '0, 1'b0);
        cycle(5'b00001, 1'b0, 1'b0, '0, 1'b1);
        cycle('0, 1'b1, 1'b0, '0, 1'b0);
        check_eq("rst_gnt_drop", 32'(gnt), 32'd0);
        repeat (8) cycle(5'b00001, m_hold, 1'b0, '0, 1'b0);
        check_log("seq_reset", '{0, 0, 0, 0, 9});

        // Randomized traffic, including weight 0, all-ones weights and resets
        r = '0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(3) == 0) r = N'($urandom);
            cw = '0;
            for (int i = 0; i < N; i++)
                cw[i*W +: W] = ($urandom_range(3) == 0) ? '0 : W'($urandom);
            cycle(r, ($urandom_range(2) == 0), ($urandom_range(39) == 0), cw,
                  ($urandom_range(299) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
